// File: rtl/mem_wb_stage.sv
// Memory stage and M/W pipeline register of the Y86-64 pipeline.
// Owns the byte-addressed little-endian data memory, the memory-stage
// status path, the W register and the sticky halt flag.
//
// Pipeline control: W_bubble loads a nop into W and wins over W_stall,
// which holds W. Once halted is set, both are ignored and W holds until
// rst_n. Memory writes are independent of W_stall; the controller is
// responsible for stalling M alongside W so a store is not repeated.
module mem_wb_stage #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  M_iCode,
  input  logic        M_Cnd,
  input  logic [2:0]  M_stat,
  input  logic [3:0]  M_rA,
  input  logic [3:0]  M_rB,
  input  logic [63:0] M_valE,
  input  logic [63:0] M_valA,
  input  logic        W_stall,
  input  logic        W_bubble,
  output logic [63:0] m_valM,
  output logic [2:0]  m_stat,
  output logic [3:0]  W_iCode,
  output logic        W_Cnd,
  output logic [2:0]  W_stat,
  output logic [3:0]  W_rA,
  output logic [3:0]  W_rB,
  output logic [63:0] W_valE,
  output logic [63:0] W_valM,
  output logic        halted
);

  localparam int IDX_W = $clog2(MEM_BYTES);
  // Highest base address whose 8-byte access still fits in memory.
  localparam logic [ADDR_W-1:0] LAST_OK = ADDR_W'(MEM_BYTES - 8);

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_ADR = 3'd3;

  logic [7:0]        mem [MEM_BYTES];
  logic              rd_en;
  logic              wr_req;
  logic              dmem_error;
  logic              wr_en;
  logic              w_frozen;
  logic [ADDR_W-1:0] mem_addr;
  logic [IDX_W-1:0]  idx;
  logic [63:0]       rd_data;

  // Decode the access type and pick the address source from the icode.
  always_comb begin
    rd_en    = 1'b0;
    wr_req   = 1'b0;
    mem_addr = '0;
    case (M_iCode)
      I_RMMOVQ, I_CALL, I_PUSHQ: begin
        wr_req   = 1'b1;
        mem_addr = ADDR_W'(M_valE);
      end
      I_MRMOVQ: begin
        rd_en    = 1'b1;
        mem_addr = ADDR_W'(M_valE);
      end
      I_RET, I_POPQ: begin
        rd_en    = 1'b1;
        mem_addr = ADDR_W'(M_valA);
      end
      default: begin
        rd_en    = 1'b0;
        wr_req   = 1'b0;
      end
    endcase
  end

  // Full-width unsigned compare: huge addresses never wrap into range.
  assign dmem_error = (rd_en | wr_req) && (mem_addr > LAST_OK);
  assign idx        = mem_addr[IDX_W-1:0];

  // Gather eight consecutive bytes, lowest address in the low byte.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < 8; i++) begin
      rd_data[8*i +: 8] = mem[idx + IDX_W'(i)];
    end
  end

  assign m_valM = (rd_en && !dmem_error) ? rd_data : 64'd0;
  assign m_stat = dmem_error ? S_ADR : M_stat;

  // Any instruction behind a faulting one, or a store during reset, must
  // leave memory untouched; all eight bytes share one enable so a store is
  // either complete or absent.
  assign wr_en = wr_req && !dmem_error && (W_stat == S_AOK) && !halted && rst_n;

  // Data memory write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 8; i++) begin
        mem[idx + IDX_W'(i)] <= M_valA[8*i +: 8];
      end
    end
  end

  assign w_frozen = halted;

  // W register: bubble beats stall, and a halted pipeline holds W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      W_iCode <= I_NOP;
      W_Cnd   <= 1'b0;
      W_stat  <= S_AOK;
      W_rA    <= R_NONE;
      W_rB    <= R_NONE;
      W_valE  <= 64'd0;
      W_valM  <= 64'd0;
    end else if (!w_frozen) begin
      if (W_bubble) begin
        W_iCode <= I_NOP;
        W_Cnd   <= 1'b0;
        W_stat  <= S_AOK;
        W_rA    <= R_NONE;
        W_rB    <= R_NONE;
        W_valE  <= 64'd0;
        W_valM  <= 64'd0;
      end else if (!W_stall) begin
        W_iCode <= M_iCode;
        W_Cnd   <= M_Cnd;
        W_stat  <= m_stat;
        W_rA    <= M_rA;
        W_rB    <= M_rB;
        W_valE  <= M_valE;
        W_valM  <= m_valM;
      end
    end
  end

  // Sticky halt: set the edge after a non-AOK status sits in W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted <= 1'b0;
    end else if (W_stat != S_AOK) begin
      halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: byte-level memory model, W register
// model and an expected-value queue compared one clock after each drive.
module tb_mem_wb_stage;

  localparam logic [143:0] W_NOP = {4'h1, 3'd1, 4'hF, 4'hF, 64'd0, 64'd0, 1'b0};

  logic        clk;
  logic        rst_n;
  logic [3:0]  M_iCode;
  logic        M_Cnd;
  logic [2:0]  M_stat;
  logic [3:0]  M_rA;
  logic [3:0]  M_rB;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic        W_stall;
  logic        W_bubble;
  logic [63:0] m_valM;
  logic [2:0]  m_stat;
  logic [3:0]  W_iCode;
  logic        W_Cnd;
  logic [2:0]  W_stat;
  logic [3:0]  W_rA;
  logic [3:0]  W_rB;
  logic [63:0] W_valE;
  logic [63:0] W_valM;
  logic        halted;

  mem_wb_stage #(.MEM_BYTES(1024), .ADDR_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .M_iCode(M_iCode), .M_Cnd(M_Cnd), .M_stat(M_stat),
    .M_rA(M_rA), .M_rB(M_rB), .M_valE(M_valE), .M_valA(M_valA),
    .W_stall(W_stall), .W_bubble(W_bubble),
    .m_valM(m_valM), .m_stat(m_stat),
    .W_iCode(W_iCode), .W_Cnd(W_Cnd), .W_stat(W_stat),
    .W_rA(W_rA), .W_rB(W_rB), .W_valE(W_valE), .W_valM(W_valM),
    .halted(halted)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  logic [143:0] exp_q[$];
  logic [7:0]   bm [0:1023];
  logic [143:0] w_model;
  logic         halt_model;
  logic [63:0]  last_valm;
  logic [2:0]   last_stat;
  int           checks;
  int           errors;

  task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_read(input int a);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = bm[a + i];
    return v;
  endfunction

  task automatic idle_inputs();
    M_iCode = 4'h1; M_Cnd = 1'b0; M_stat = 3'd1; M_rA = 4'hF; M_rB = 4'hF;
    M_valE = '0; M_valA = '0; W_stall = 1'b0; W_bubble = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    #2;
    check("rst_w", {W_iCode, W_stat, W_rA, W_rB, W_valE, W_valM, W_Cnd}, W_NOP);
    check("rst_halted", halted, 1'b0);
    w_model    = W_NOP;
    halt_model = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Driver: one instruction in M for one clock, with model update.
  task automatic cycle(input logic [3:0] ic, input logic [2:0] st,
                       input logic [63:0] ve, input logic [63:0] va,
                       input logic stall = 1'b0, input logic bubble = 1'b0);
    logic rd, wr, err, we, new_halt, cnd;
    logic [63:0] addr, ev;
    logic [2:0] es;
    logic [3:0] ra, rb;
    logic [143:0] got;
    @(negedge clk);
    ra  = 4'($urandom_range(0, 15));
    rb  = 4'($urandom_range(0, 15));
    cnd = 1'($urandom_range(0, 1));
    M_iCode = ic; M_stat = st; M_valE = ve; M_valA = va;
    M_rA = ra; M_rB = rb; M_Cnd = cnd; W_stall = stall; W_bubble = bubble;
    rd = 1'b0; wr = 1'b0; addr = '0;
    case (ic)
      4'h4, 4'h8, 4'hA: begin wr = 1'b1; addr = ve; end
      4'h5:             begin rd = 1'b1; addr = ve; end
      4'h9, 4'hB:       begin rd = 1'b1; addr = va; end
      default:          ;
    endcase
    err = (rd | wr) && (addr > 64'd1016);
    ev  = (rd && !err) ? model_read(int'(addr[9:0])) : 64'd0;
    es  = err ? 3'd3 : st;
    #1;
    check("m_stat", m_stat, es);
    check("m_valM", m_valM, ev);
    last_valm = m_valM;
    last_stat = m_stat;
    we       = wr && !err && (w_model[139:137] == 3'd1) && !halt_model;
    new_halt = halt_model | (w_model[139:137] != 3'd1);
    if (!halt_model) begin
      if (bubble) w_model = W_NOP;
      else if (!stall) w_model = {ic, es, ra, rb, ve, ev, cnd};
    end
    halt_model = new_halt;
    if (we) for (int i = 0; i < 8; i++) bm[int'(addr[9:0]) + i] = va[8*i +: 8];
    exp_q.push_back(w_model);
    @(posedge clk);
    #1;
    got = {W_iCode, W_stat, W_rA, W_rB, W_valE, W_valM, W_Cnd};
    if (exp_q.size() == 0) check("w_queue_empty", 1'b1, 1'b0);
    else check("w_reg", got, exp_q.pop_front());
    check("halted", halted, halt_model);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 1024; i++) bm[i] = 8'h00;
    rst_n = 1'b0;
    idle_inputs();
    w_model    = W_NOP;
    halt_model = 1'b0;

    // Reset then idle
    do_reset();
    cycle(4'h1, 3'd1, 64'd0, 64'd0);
    check("idle_icode", W_iCode, 4'h1);
    check("idle_halted", halted, 1'b0);

    // Store then load
    cycle(4'h4, 3'd1, 64'h10, 64'h1122334455667788);
    cycle(4'h5, 3'd1, 64'h10, 64'd0);
    check("load_valm", last_valm, 64'h1122334455667788);
    check("load_wvalm", W_valM, 64'h1122334455667788);
    check("byte_10", last_valm[7:0], 8'h88);
    cycle(4'h5, 3'd1, 64'h11, 64'd0);
    check("load_unaligned", last_valm, 64'h0011223344556677);

    // Pop/ret use valA, push uses valE
    cycle(4'h4, 3'd1, 64'h20, 64'h2020202020202020);
    cycle(4'h4, 3'd1, 64'h28, 64'h2828282828282828);
    cycle(4'hB, 3'd1, 64'h28, 64'h20);
    check("pop_addr", last_valm, 64'h2020202020202020);
    cycle(4'hA, 3'd1, 64'h18, 64'h00000000CAFEBABE);
    cycle(4'h9, 3'd1, 64'h40, 64'h18);
    check("ret_after_push", last_valm, 64'h00000000CAFEBABE);

    // Boundary accesses
    cycle(4'h4, 3'd1, 64'd1016, 64'h0102030405060708);
    cycle(4'h5, 3'd1, 64'd1016, 64'd0);
    check("edge_stat", last_stat, 3'd1);
    check("edge_valm", last_valm, 64'h0102030405060708);
    cycle(4'h5, 3'd1, 64'd1017, 64'd0);
    check("over_stat", last_stat, 3'd3);
    check("over_valm", last_valm, 64'd0);
    cycle(4'h1, 3'd1, 64'd0, 64'd0);
    do_reset();
    cycle(4'h4, 3'd1, 64'hFFFFFFFFFFFFFFFC, 64'h9999999999999999);
    check("wrap_stat", last_stat, 3'd3);
    do_reset();
    cycle(4'h5, 3'd1, 64'd1016, 64'd0);
    check("wrap_no_write", last_valm, 64'h0102030405060708);

    // Halt sequencing
    cycle(4'h4, 3'd1, 64'h40, 64'hAAAAAAAAAAAAAAAA);
    cycle(4'h0, 3'd2, 64'd0, 64'd0);
    cycle(4'h4, 3'd1, 64'h40, 64'h5555555555555555);
    check("halt_set", halted, 1'b1);
    cycle(4'h1, 3'd1, 64'd0, 64'd0, 1'b0, 1'b1);
    cycle(4'h5, 3'd1, 64'h10, 64'd0, 1'b0, 1'b1);
    check("halt_hold", halted, 1'b1);
    do_reset();
    cycle(4'h5, 3'd1, 64'h40, 64'd0);
    check("halt_no_write", last_valm, 64'hAAAAAAAAAAAAAAAA);

    // Stall holds W for three edges; stall with bubble loads a nop
    cycle(4'h5, 3'd1, 64'h10, 64'd0);
    cycle(4'h6, 3'd1, 64'h1234, 64'h5, 1'b1, 1'b0);
    cycle(4'h2, 3'd1, 64'h77, 64'h6, 1'b1, 1'b0);
    cycle(4'h3, 3'd1, 64'h99, 64'h7, 1'b1, 1'b0);
    check("stall_hold", W_valM, 64'h1122334455667788);
    cycle(4'h6, 3'd1, 64'h55, 64'h8, 1'b1, 1'b1);
    check("stall_bubble", {W_iCode, W_rA, W_rB}, {4'h1, 4'hF, 4'hF});

    // Reset landing on a store edge discards the store
    @(negedge clk);
    M_iCode = 4'h4; M_stat = 3'd1; M_valE = 64'h80; M_valA = 64'hDEADBEEFDEADBEEF;
    W_stall = 1'b0; W_bubble = 1'b0;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midwrite_rst_w", {W_iCode, W_stat, W_rA, W_rB, W_valE, W_valM, W_Cnd}, W_NOP);
    w_model = W_NOP; halt_model = 1'b0; exp_q.delete();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    cycle(4'h5, 3'd1, 64'h80, 64'd0);
    check("midwrite_none", last_valm, 64'd0);

    // Random traffic, all in range with AOK status
    for (int n = 0; n < 60; n++) begin
      logic [3:0]  ic;
      logic [63:0] ve, va;
      ic = 4'($urandom_range(0, 11));
      ve = 64'($urandom_range(0, 1016));
      if (ic == 4'h9 || ic == 4'hB) va = 64'($urandom_range(0, 1016));
      else va = {$urandom, $urandom};
      cycle(ic, 3'd1, ve, va, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
